// File: rtl/acc16_seq.sv
// Group accumulator that drives an external registered 16-bit adder.
// It accumulates operands and reports the sum, a sticky overflow flag and a count for each group.
module acc16_seq #(
  parameter int unsigned ADD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_sub,
  input  logic        in_last,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_s,
  input  logic        add_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_ovf,
  output logic [7:0]  out_cnt
);

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMER_W = (ADD_LAT == 0) ? 1 : $clog2(ADD_LAT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [TIMER_W-1:0] TIMER_END = TIMER_W'(ADD_LAT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                last_q, last_d;
  logic                sub_q, sub_d;
  logic [DATA_W-1:0]   add_a_q, add_a_d;
  logic [DATA_W-1:0]   add_b_q, add_b_d;
  logic                add_cin_q, add_cin_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    last_d    = last_q;
    sub_d     = sub_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_cin_d = add_cin_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          add_a_d   = acc_q;
          add_b_d   = in_sub ? ~in_data : in_data;
          add_cin_d = in_sub;
          last_d    = in_last;
          sub_d     = in_sub;
          timer_d   = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (timer_q == TIMER_END) begin
          acc_d   = add_s;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          // For subtraction a missing carry-out means a borrow
          ovf_d   = ovf_q | (sub_q ? ~add_cout : add_cout);
          state_d = last_q ? DONE : IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      timer_q     <= '0;
      last_q      <= 1'b0;
      sub_q       <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      last_q      <= last_d;
      sub_q       <= sub_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_cnt   = cnt_q;

endmodule

// File: doc/acc16_seq.md
ACC16_SEQ -- requirements
Module: acc16_seq

Interface
REQ-001 Parameter: ADD_LAT, default 2, cycles from add_a/add_b/add_cin driven to add_s/add_cout valid (registered 16-bit adder: input reg + output reg).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock, shared with the downstream adder.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  operand present.
REQ-006 in_ready  out  1  block accepts operand this cycle.
REQ-007 in_data  in  16  unsigned operand.
REQ-008 in_sub  in  1  1 = subtract operand from accumulator, 0 = add.
REQ-009 in_last  in  1  operand closes the current group.
REQ-010 add_a, add_b  out  16 each  registered adder operands.
REQ-011 add_cin  out  1  registered adder carry-in.
REQ-012 add_s  in  16  adder sum.
REQ-013 add_cout  in  1  adder carry-out.
REQ-014 out_valid  out  1  group result present.
REQ-015 out_ready  in  1  consumer accepts result.
REQ-016 out_sum  out  16  final accumulator value.
REQ-017 out_ovf  out  1  sticky unsigned overflow/borrow flag for the group.
REQ-018 out_cnt  out  8  operands accepted in the group, saturating.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT and DONE; acc (16b), ovf (1b), cnt (8b), last_q, sub_q and timer are internal registers.
REQ-020 IDLE: in_ready=1; handshake on in_valid&in_ready.
- Register add_a<=acc.
- Register add_b<=in_data (add) or ~in_data (sub).
- Register add_cin<=in_sub.
- Latch last_q<=in_last and sub_q<=in_sub.
- Set timer<=0 and go to WAIT.
REQ-021 WAIT: in_ready=0; timer increments each cycle.
- When timer==ADD_LAT, capture acc<=add_s and cnt<=min(cnt+1,255).
- On the same capture, ovf<=ovf|add_cout (add) or ovf|~add_cout (sub).
- After capture, go to DONE if last_q, else IDLE.
REQ-022 Capture SHALL occur on the (ADD_LAT+1)th rising edge after the accept edge; throughput is one operand per ADD_LAT+2 cycles.
REQ-023 add_a/add_b/add_cin SHALL hold stable from the accept edge until the capture edge.
REQ-024 DONE: out_valid=1, in_ready=0; out_sum=acc, out_ovf=ovf, out_cnt=cnt.
- All outputs SHALL hold stable while out_ready=0.
REQ-025 DONE with out_ready=1: the result transfers, acc, ovf and cnt clear to 0, and the FSM goes to IDLE; in_valid in that cycle is ignored.
REQ-026 in_valid in WAIT or DONE SHALL be ignored with no state change; the source holds data.
REQ-027 Arithmetic SHALL be modulo 2^16; a borrow from acc=0 yields wrap plus ovf=1.
REQ-028 cnt SHALL saturate at 255 while accumulation continues.
REQ-029 out_valid SHALL be 0 in IDLE and WAIT.

Reset
REQ-030 On rst=1 at a clock edge, in any state, the block SHALL set state=IDLE and clear acc, ovf, cnt, timer, last_q, sub_q, add_a, add_b, add_cin, out_valid, out_sum, out_ovf and out_cnt to 0.
- in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-031 Reset during WAIT SHALL discard the in-flight adder result; no capture occurs after reset.
REQ-032 The system SHALL reset the adder in the same cycle, so stale add_s is never captured.

Verification
REQ-033 Reset: hold rst 2 cycles -> all outputs 0, in_ready=1, out_valid=0.
REQ-034 Adds 0x0001, 0x0002, 0x0003(last), ADD_LAT=2 -> out_sum=0x0006, out_ovf=0, out_cnt=3; out_valid rises exactly 3 edges after the last accept; in_ready=0 for 3 cycles after each accept.
REQ-035 Overflow: 0xFFFF, then add 0x0002(last) -> out_sum=0x0001, out_ovf=1, out_cnt=2.
REQ-036 Subtract:
- 0x0005, then sub 0x0007(last) -> out_sum=0xFFFE, out_ovf=1.
- 0x0007, then sub 0x0005(last) -> out_sum=0x0002, out_ovf=0.
REQ-037 Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_valid and outputs stable, no operand accepted; out_ready=1 -> next group starts from acc=0, cnt=0.
REQ-038 Reset mid-WAIT (one cycle after accepting 0x1234) -> no capture occurs; next group 0x0010(last) -> out_sum=0x0010, out_cnt=1, out_ovf=0.
